// File: rtl/bpsk_modulator.sv
// -----------------------------------------------------------------------------
// bpsk_modulator
//
// BPSK baseband transmitter. A frame is PREAMBLE_LEN symbols of +1 followed by
// as many data symbols as the upstream source supplies. Each symbol is held
// for SPS samples, then rotated by a 32-bit NCO carrier offset. The result is
// scaled to AMP and emitted as signed 16-bit I/Q with a valid strobe.
//
// Build option:
//   BPSK_DIFF_ENC_EN  defined   -> differential encoding d_k = d_(k-1) ^ b_k,
//                                  with d cleared at the start of each frame
//                     undefined -> d_k = b_k, no encoder state
//
// Parameters:
//   SPS           samples per symbol (>= 2)
//   PREAMBLE_LEN  preamble symbols, all +1 (>= 1)
//   AMP           output amplitude in Q1.15 (1..32767)
//
// Ports:
//   clk_i         clock
//   rst_ni        asynchronous active-low reset
//   start_i       begin a frame (only looked at while idle)
//   freq_word_i   NCO phase increment per sample, latched when start_i is taken
//   bit_i         data bit: 0 -> +1, 1 -> -1
//   bit_valid_i   bit_i is valid
//   bit_ready_o   a bit is taken when bit_valid_i & bit_ready_o
//   dataI_o       signed I sample (0 when valid_o is low)
//   dataQ_o       signed Q sample (0 when valid_o is low)
//   valid_o       dataI_o/dataQ_o carry a sample
//   busy_o        a frame is in progress (including pipeline drain)
//   done_o        one-cycle pulse on the last valid sample of a frame
// -----------------------------------------------------------------------------
module bpsk_modulator #(
    parameter int SPS          = 4,
    parameter int PREAMBLE_LEN = 16,
    parameter int AMP          = 16384
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               start_i,
    input  logic [31:0]        freq_word_i,
    input  logic               bit_i,
    input  logic               bit_valid_i,
    output logic               bit_ready_o,
    output logic signed [15:0] dataI_o,
    output logic signed [15:0] dataQ_o,
    output logic               valid_o,
    output logic               busy_o,
    output logic               done_o
);

    localparam int CNT_W = (SPS > 1) ? $clog2(SPS) : 1;
    localparam int PRE_W = $clog2(PREAMBLE_LEN + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SPS - 1);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PREAMBLE_LEN - 1);
    localparam logic signed [31:0] AMP_S = 32'(AMP);

    // Two drain states keep busy_o high while the last sample walks through
    // the two-register output pipe, so done_o lands on the final valid_o.
    typedef enum logic [2:0] {
        S_IDLE,
        S_PREAMBLE,
        S_DATA,
        S_DRAIN1,
        S_DRAIN2
    } state_t;

    state_t state, state_next;

    logic [CNT_W-1:0]   cnt;
    logic [PRE_W-1:0]   psym;
    logic [31:0]        acc;
    logic [31:0]        freq;
    logic               sym;
    logic               sym_boundary;
    logic               transfer;
    logic               d_next;

    // Full-wave sine table, evaluated at elaboration time.
    logic signed [15:0] sin_t [256];

    for (genvar k = 0; k < 256; k++) begin : g_lut
        localparam real ANG = 6.283185307179586 * k / 256.0;
        localparam int  VAL = int'(32767.0 * $sin(ANG));
        assign sin_t[k] = 16'(VAL);
    end

    // Scale a table value by AMP (floor shift) and apply the symbol sign.
    function automatic logic signed [15:0] scale(input logic signed [15:0] v,
                                                 input logic               neg);
        logic signed [31:0] prod;
        logic signed [31:0] shifted;
        prod    = AMP_S * 32'(v);
        shifted = prod >>> 15;
        if (neg) shifted = -shifted;
        return shifted[15:0];
    endfunction

    assign sym_boundary = (cnt == CNT_LAST);
    assign transfer     = bit_ready_o & bit_valid_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state <= S_IDLE;
        else         state <= state_next;
    end

    always_comb begin
        state_next  = state;
        busy_o      = (state != S_IDLE);
        bit_ready_o = 1'b0;
        case (state)
            S_IDLE: begin
                if (start_i) state_next = S_PREAMBLE;
            end
            S_PREAMBLE: begin
                if (sym_boundary && (psym == PRE_LAST)) begin
                    bit_ready_o = 1'b1;
                    state_next  = bit_valid_i ? S_DATA : S_DRAIN1;
                end
            end
            S_DATA: begin
                if (sym_boundary) begin
                    bit_ready_o = 1'b1;
                    if (!bit_valid_i) state_next = S_DRAIN1;
                end
            end
            S_DRAIN1: state_next = S_DRAIN2;
            S_DRAIN2: state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    // Counters, NCO and current symbol. Everything is held at its start value
    // while idle so the first sample of a frame sees phase 0 and symbol +1.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt  <= '0;
            psym <= '0;
            acc  <= '0;
            freq <= '0;
            sym  <= 1'b0;
        end else if (state == S_IDLE) begin
            cnt  <= '0;
            psym <= '0;
            acc  <= '0;
            sym  <= 1'b0;
            if (start_i) freq <= freq_word_i;
        end else begin
            cnt <= sym_boundary ? '0 : cnt + 1'b1;
            acc <= acc + freq;
            if (sym_boundary && (state == S_PREAMBLE)) psym <= psym + 1'b1;
            if (transfer) sym <= d_next;
        end
    end

`ifdef BPSK_DIFF_ENC_EN
    logic diff;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)               diff <= 1'b0;
        else if (state == S_IDLE)  diff <= 1'b0;
        else if (transfer)         diff <= d_next;
    end

    assign d_next = diff ^ bit_i;
`else
    assign d_next = bit_i;
`endif

    // ---- stage p0: sample selection from current NCO phase and symbol ----
    logic       vld_p0;
    logic       last_p0;
    logic [7:0] idx_p0;
    logic [7:0] cidx_p0;

    assign vld_p0  = (state == S_PREAMBLE) || (state == S_DATA);
    assign last_p0 = bit_ready_o & ~bit_valid_i;
    assign idx_p0  = acc[31:24];
    assign cidx_p0 = idx_p0 + 8'd64;

    // ---- stage p1: table lookup ----
    logic               vld_p1;
    logic               last_p1;
    logic               neg_p1;
    logic signed [15:0] cos_p1;
    logic signed [15:0] sin_p1;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vld_p1  <= 1'b0;
            last_p1 <= 1'b0;
            neg_p1  <= 1'b0;
        end else begin
            vld_p1  <= vld_p0;
            last_p1 <= vld_p0 & last_p0;
            neg_p1  <= sym;
        end
    end

    always_ff @(posedge clk_i) begin
        cos_p1 <= sin_t[cidx_p0];
        sin_p1 <= sin_t[idx_p0];
    end

    // ---- stage p2: amplitude scaling, sign, output registers ----
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            dataI_o <= '0;
            dataQ_o <= '0;
            valid_o <= 1'b0;
            done_o  <= 1'b0;
        end else begin
            valid_o <= vld_p1;
            done_o  <= vld_p1 & last_p1;
            dataI_o <= vld_p1 ? scale(cos_p1, neg_p1) : 16'sd0;
            dataQ_o <= vld_p1 ? scale(sin_p1, neg_p1) : 16'sd0;
        end
    end

endmodule

// File: tb/tb_bpsk_modulator.sv
module tb_bpsk_modulator;

    localparam int  SPS = 4;
    localparam int  PRE = 8;
    localparam int  AMP = 16384;
    localparam real PI  = 3.141592653589793;

    logic               clk         = 1'b0;
    logic               rst_ni      = 1'b0;
    logic               start_i     = 1'b0;
    logic [31:0]        freq_word_i = '0;
    logic               bit_i       = 1'b0;
    logic               bit_valid_i = 1'b0;
    logic               bit_ready_o;
    logic signed [15:0] dataI_o;
    logic signed [15:0] dataQ_o;
    logic               valid_o;
    logic               busy_o;
    logic               done_o;

    bpsk_modulator #(
        .SPS          (SPS),
        .PREAMBLE_LEN (PRE),
        .AMP          (AMP)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_ni),
        .start_i     (start_i),
        .freq_word_i (freq_word_i),
        .bit_i       (bit_i),
        .bit_valid_i (bit_valid_i),
        .bit_ready_o (bit_ready_o),
        .dataI_o     (dataI_o),
        .dataQ_o     (dataQ_o),
        .valid_o     (valid_o),
        .busy_o      (busy_o),
        .done_o      (done_o)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // Frame model: a frame is a timeline indexed by m_c, the cycle count since
    // the start was taken. Sample n is produced at m_c = n + 2.
    bit          m_active = 1'b0;
    int          m_c      = 0;
    int          m_len    = 0;
    logic [31:0] m_freq   = '0;
    bit          m_sym[$];

    bit plan_bits[$];
    int cap_i[$];
    int cap_q[$];
    int ready_cnt = 0;
    int done_cnt  = 0;
    int k         = 0;
    bit acc_now   = 1'b0;

    function automatic int sin_t(input int idx);
        return int'(32767.0 * $sin(2.0 * PI * idx / 256.0));
    endfunction

    function automatic int amp_scale(input int v);
        return int'($floor(real'(AMP * v) / 32768.0));
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Per-cycle compare against the model timeline.
    always @(negedge clk) begin
        int     eb, ev, er, ed, ei, eq, n, s, idx, sg;
        longint ph;
        eb = 0; ev = 0; er = 0; ed = 0; ei = 0; eq = 0;
        if (!rst_ni) begin
            m_active = 1'b0;
        end else if (m_active) begin
            eb = 1;
            er = (m_c < m_len && (m_c % SPS) == SPS - 1 && m_c >= (PRE - 1) * SPS) ? 1 : 0;
            if (m_c >= 2) begin
                ev  = 1;
                ed  = (m_c == m_len + 1) ? 1 : 0;
                n   = m_c - 2;
                ph  = (longint'(n) * longint'(m_freq)) % 64'sh1_0000_0000;
                idx = int'(ph / 64'sh100_0000);
                s   = n / SPS;
                sg  = (s < PRE) ? 1 : (m_sym[s - PRE] ? -1 : 1);
                ei  = sg * amp_scale(sin_t((idx + 64) % 256));
                eq  = sg * amp_scale(sin_t(idx));
            end
        end
        chk("busy",  int'(busy_o),      eb);
        chk("valid", int'(valid_o),     ev);
        chk("ready", int'(bit_ready_o), er);
        chk("done",  int'(done_o),      ed);
        chk("dataI", int'(dataI_o),     ei);
        chk("dataQ", int'(dataQ_o),     eq);
        if (valid_o) begin
            cap_i.push_back(int'(dataI_o));
            cap_q.push_back(int'(dataQ_o));
        end
        if (bit_ready_o) ready_cnt++;
        if (done_o)      done_cnt++;
        if (rst_ni) begin
            if (m_active) begin
                if (m_c == m_len + 1) m_active = 1'b0;
                else                  m_c++;
            end else if (start_i) begin
                bit d;
                m_active = 1'b1;
                m_c      = 0;
                m_freq   = freq_word_i;
                m_len    = (PRE + plan_bits.size()) * SPS;
                m_sym.delete();
                d = 1'b0;
                foreach (plan_bits[i]) begin
`ifdef BPSK_DIFF_ENC_EN
                    d = d ^ plan_bits[i];
`else
                    d = plan_bits[i];
`endif
                    m_sym.push_back(d);
                end
            end
        end
    end

    // Advance one clock; returns at posedge+1 with handshake bookkeeping done.
    task automatic cycle_step();
        @(negedge clk);
        acc_now = bit_valid_i && bit_ready_o;
        @(posedge clk);
        #1;
        if (acc_now) k++;
    endtask

    task automatic drive_bits();
        if (k < plan_bits.size()) begin
            bit_valid_i = bit_ready_o ? 1'b1 : 1'($urandom_range(0, 1));
            bit_i       = bit_valid_i ? plan_bits[k] : 1'($urandom_range(0, 1));
        end else begin
            bit_valid_i = 1'b0;
            bit_i       = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic set_bits(input int n, input logic [7:0] v);
        plan_bits.delete();
        for (int i = 0; i < n; i++) plan_bits.push_back(v[i]);
    endtask

    // Run one frame; abort_at >= 0 pulls reset when the model reaches that cycle.
    task automatic run_frame(input logic [31:0] f, input int abort_at);
        int budget;
        cap_i.delete();
        cap_q.delete();
        ready_cnt   = 0;
        done_cnt    = 0;
        k           = 0;
        bit_valid_i = 1'b0;
        freq_word_i = f;
        start_i     = 1'b1;
        cycle_step();
        start_i = 1'b0;
        budget  = 0;
        while (m_active && budget < 500) begin
            freq_word_i = $urandom;
            if (abort_at >= 0 && m_c == abort_at) rst_ni = 1'b0;
            start_i = (m_c + 4 < m_len) ? ($urandom_range(0, 3) == 0) : 1'b0;
            drive_bits();
            cycle_step();
            budget++;
        end
        chk("frame_ended", int'(m_active), 0);
        start_i     = 1'b0;
        bit_valid_i = 1'b0;
        if (!rst_ni) begin
            cycle_step();
            cycle_step();
            rst_ni = 1'b1;
            cycle_step();
        end
    endtask

    task automatic quarter_check(input string tag);
        chk({tag, "_I0"}, cap_i[0], 16383);
        chk({tag, "_Q0"}, cap_q[0], 0);
        chk({tag, "_I1"}, cap_i[1], 0);
        chk({tag, "_Q1"}, cap_q[1], 16383);
        chk({tag, "_I2"}, cap_i[2], -16384);
        chk({tag, "_Q2"}, cap_q[2], 0);
        chk({tag, "_I3"}, cap_i[3], 0);
        chk({tag, "_Q3"}, cap_q[3], -16384);
        chk({tag, "_I4"}, cap_i[4], 16383);
    endtask

    initial begin
        int n;
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1;
        rst_ni = 1'b1;
        cycle_step();

        // freq 0, no data: 32 samples of (16383, 0)
        set_bits(0, 8'h00);
        run_frame(32'h0, -1);
        chk("A_count",  cap_i.size(), 32);
        chk("A_I0",     cap_i[0], 16383);
        chk("A_Q0",     cap_q[0], 0);
        chk("A_I31",    cap_i[31], 16383);
        chk("A_ready",  ready_cnt, 1);
        chk("A_done",   done_cnt, 1);

        // freq 0, bits 1,0,1
        set_bits(3, 8'b0000_0101);
        run_frame(32'h0, -1);
        chk("B_count", cap_i.size(), 44);
        chk("B_I31",   cap_i[31], 16383);
`ifdef BPSK_DIFF_ENC_EN
        chk("B_I32",   cap_i[32], -16383);
        chk("B_I36",   cap_i[36], -16383);
        chk("B_I40",   cap_i[40], 16383);
`else
        chk("B_I32",   cap_i[32], -16383);
        chk("B_I35",   cap_i[35], -16383);
        chk("B_I36",   cap_i[36], 16383);
        chk("B_I40",   cap_i[40], -16383);
        chk("B_I43",   cap_i[43], -16383);
`endif
        chk("B_ready", ready_cnt, 4);
        chk("B_done",  done_cnt, 1);

        // quarter-turn per sample
        set_bits(0, 8'h00);
        run_frame(32'h4000_0000, -1);
        quarter_check("C");

        // bits 1,1,0
        set_bits(3, 8'b0000_0011);
        run_frame(32'h0, -1);
        chk("D_I32", cap_i[32], -16383);
`ifdef BPSK_DIFF_ENC_EN
        chk("D_I36", cap_i[36], 16383);
`else
        chk("D_I36", cap_i[36], -16383);
`endif
        chk("D_I40", cap_i[40], 16383);

        // randomized frames with random handshakes and ignored starts
        for (int r = 0; r < 40; r++) begin
            n = $urandom_range(0, 6);
            set_bits(n, 8'($urandom));
            run_frame(($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 1) << 30) : 32'($urandom), -1);
            chk("R_count", cap_i.size(), (PRE + n) * SPS);
            chk("R_done",  done_cnt, 1);
            chk("R_ready", ready_cnt, n + 1);
            repeat ($urandom_range(0, 3)) cycle_step();
        end

        // reset mid-DATA, then a clean frame
        set_bits(5, 8'($urandom));
        run_frame(32'($urandom), PRE * SPS + 6);
        chk("abort_done", done_cnt, 0);
        set_bits(0, 8'h00);
        run_frame(32'h4000_0000, -1);
        quarter_check("E");

        repeat (3) cycle_step();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
